// File: rtl/fkp_pkg.sv
// rtl/fkp_pkg.sv - shared types, constants and helpers for finger_key_player
//
// Purpose : FSM state type, screen/key geometry and the tone half-period table.
// Ports   : none (package).
package fkp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAND = 2'd1,
      PLAY = 2'd2
   } fkp_state_t;

   localparam int unsigned KEY_W   = 80;
   localparam int unsigned FRAME_W = 640;

   // Square-wave half periods in 25 MHz cycles, C4 .. C5.
   localparam logic [15:0] HALF_PERIOD [0:7] = '{
      16'd47778, 16'd42566, 16'd37921, 16'd35793,
      16'd31888, 16'd28409, 16'd25310, 16'd23889
   };

   // Key index = x / KEY_W for x < FRAME_W, built as a compare chain.
   function automatic logic [2:0] key_of_x(input logic [9:0] x);
      logic [2:0] k;
      k = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (x >= 10'(i * KEY_W)) begin
            k = 3'(i);
         end
      end
      return k;
   endfunction

endpackage

// File: rtl/finger_key_player_if.sv
// rtl/finger_key_player_if.sv - tracker-to-player signal bundle
//
// Purpose : groups the tracker centroid inputs and the key/tone outputs.
// Modports: master - tracker/bench side (drives vsync, center_x, center_y)
//           slave  - finger_key_player side (drives key_idx, note_on,
//                    key_event, octave, buzzer)
interface finger_key_player_if;
   logic       vsync;
   logic [9:0] center_x;
   logic [9:0] center_y;
   logic [2:0] key_idx;
   logic       note_on;
   logic       key_event;
   logic       octave;
   logic       buzzer;

   modport master (
      output vsync, center_x, center_y,
      input  key_idx, note_on, key_event, octave, buzzer
   );

   modport slave (
      input  vsync, center_x, center_y,
      output key_idx, note_on, key_event, octave, buzzer
   );
endinterface

// File: rtl/fkp_tone_gen.sv
// rtl/fkp_tone_gen.sv - square-wave tone generator
//
// Purpose : toggles buzzer every half_period cycles while enabled.
// Ports   : clk, reset (async, active-high), enable, half_period[15:0] in;
//           buzzer out.
module fkp_tone_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] half_period,
   output logic        buzzer
);

   logic [15:0] tcnt_q, tcnt_d;
   logic        buzzer_q, buzzer_d;

   always_comb begin
      tcnt_d   = '0;
      buzzer_d = 1'b0;
      if (enable) begin
         if (tcnt_q == half_period - 16'd1) begin
            tcnt_d   = '0;
            buzzer_d = ~buzzer_q;
         end else begin
            tcnt_d   = tcnt_q + 16'd1;
            buzzer_d = buzzer_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcnt_q   <= '0;
         buzzer_q <= 1'b0;
      end else begin
         tcnt_q   <= tcnt_d;
         buzzer_q <= buzzer_d;
      end
   end

   // Gating with enable drops the pin in the very cycle the note ends,
   // rather than one cycle later when the flop clears.
   assign buzzer = buzzer_q & enable;

endmodule

// File: rtl/finger_key_player.sv
// rtl/finger_key_player.sv - fingertip position to debounced piano tone
//
// Purpose : samples the tracker centroid once per frame, maps it to one of
//           eight keys, debounces entry/exit over whole frames and drives a
//           square-wave tone.
// Ports   : clk, reset (async, active-high);
//           bus (finger_key_player_if.slave): vsync, center_x, center_y in;
//           key_idx, note_on, key_event, octave, buzzer out.
// Options : FKP_OCTAVE_EN - upper half of the key band plays one octave up.
module finger_key_player
   import fkp_pkg::*;
#(
   parameter int KEY_Y_MIN      = 360,
   parameter int KEY_Y_MAX      = 479,
   parameter int STABLE_FRAMES  = 3,
   parameter int RELEASE_FRAMES = 2
) (
   input logic                clk,
   input logic                reset,
   finger_key_player_if.slave bus
);

   localparam logic [9:0] Y_MIN     = 10'(KEY_Y_MIN);
   localparam logic [9:0] Y_MAX     = 10'(KEY_Y_MAX);
   localparam logic [9:0] X_LIMIT   = 10'(FRAME_W);
   localparam logic [3:0] STABLE_N  = 4'(STABLE_FRAMES);
   localparam logic [3:0] RELEASE_N = 4'(RELEASE_FRAMES);

   fkp_state_t  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  cand_q, cand_d;
   logic        cand_oct_q, cand_oct_d;
   logic [2:0]  key_idx_q, key_idx_d;
   logic        octave_q, octave_d;
   logic        key_event_q, key_event_d;
   logic        vsync_q, vsync_d;
   logic        sample_tick_q, sample_tick_d;

   logic        frame_tick;
   logic        zone_valid;
   logic [2:0]  zone_key;
   logic        zone_oct;
   logic [3:0]  cnt_inc;
   logic [15:0] half_period;
   logic        note_on;

   // Falling vsync marks the end of a frame; sampling waits one more cycle
   // so the tracker has already updated its centroid.
   assign frame_tick = vsync_q & ~bus.vsync;

   assign zone_valid = (bus.center_x < X_LIMIT) &&
                       (bus.center_y >= Y_MIN) && (bus.center_y <= Y_MAX);
   assign zone_key   = key_of_x(bus.center_x);
   assign cnt_inc    = cnt_q + 4'd1;
   assign note_on    = (state_q == PLAY);

`ifdef FKP_OCTAVE_EN
   localparam logic [9:0] Y_MID = 10'((KEY_Y_MIN + KEY_Y_MAX) >> 1);

   assign zone_oct    = (bus.center_y < Y_MID);
   assign half_period = octave_q ? (HALF_PERIOD[key_idx_q] >> 1)
                                 : HALF_PERIOD[key_idx_q];
`else
   assign zone_oct    = 1'b0;
   assign half_period = HALF_PERIOD[key_idx_q];
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cand_d        = cand_q;
      cand_oct_d    = cand_oct_q;
      key_idx_d     = key_idx_q;
      octave_d      = octave_q;
      key_event_d   = 1'b0;
      vsync_d       = bus.vsync;
      sample_tick_d = frame_tick;

      if (sample_tick_q) begin
         case (state_q)
            IDLE: begin
               if (zone_valid) begin
                  if (STABLE_N == 4'd1) begin
                     state_d     = PLAY;
                     key_idx_d   = zone_key;
                     octave_d    = zone_oct;
                     cnt_d       = '0;
                     key_event_d = 1'b1;
                  end else begin
                     state_d    = CAND;
                     cand_d     = zone_key;
                     cand_oct_d = zone_oct;
                     cnt_d      = 4'd1;
                  end
               end
            end
            CAND: begin
               if (!zone_valid) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (zone_key == cand_q && zone_oct == cand_oct_q) begin
                  if (cnt_inc == STABLE_N) begin
                     state_d     = PLAY;
                     key_idx_d   = cand_q;
                     octave_d    = cand_oct_q;
                     cnt_d       = '0;
                     key_event_d = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  // A new key restarts the candidate count from one frame.
                  cand_d     = zone_key;
                  cand_oct_d = zone_oct;
                  cnt_d      = 4'd1;
               end
            end
            PLAY: begin
               // cnt counts consecutive off-key frames; any other key,
               // including an invalid zone, only ever leads back to IDLE.
               if (zone_valid && zone_key == key_idx_q && zone_oct == octave_q) begin
                  cnt_d = '0;
               end else if (cnt_inc == RELEASE_N) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         cand_q        <= '0;
         cand_oct_q    <= 1'b0;
         key_idx_q     <= '0;
         octave_q      <= 1'b0;
         key_event_q   <= 1'b0;
         vsync_q       <= 1'b0;
         sample_tick_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cand_q        <= cand_d;
         cand_oct_q    <= cand_oct_d;
         key_idx_q     <= key_idx_d;
         octave_q      <= octave_d;
         key_event_q   <= key_event_d;
         vsync_q       <= vsync_d;
         sample_tick_q <= sample_tick_d;
      end
   end

   fkp_tone_gen u_tone (
      .clk         (clk),
      .reset       (reset),
      .enable      (note_on),
      .half_period (half_period),
      .buzzer      (bus.buzzer)
   );

   assign bus.key_idx   = key_idx_q;
   assign bus.note_on   = note_on;
   assign bus.key_event = key_event_q;
   assign bus.octave    = octave_q;

endmodule

// File: tb/tb_finger_key_player.sv
// tb/tb_finger_key_player.sv - self-checking bench for finger_key_player
module tb_finger_key_player;

`ifdef FKP_OCTAVE_EN
   localparam bit OCT_EN = 1'b1;
   localparam int HP_KEY1 = 21283;
`else
   localparam bit OCT_EN = 1'b0;
   localparam int HP_KEY1 = 42566;
`endif

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       on;
      logic [2:0] key;
      logic       oct;
      int         ev;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   finger_key_player_if bus ();

   finger_key_player dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   int   ev_cnt;
   logic on_s [4];
   logic ev_s [4];
   vec_t vecs [26];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input int x, input int y, input bit on,
                               input int key, input bit oct, input int ev);
      vec_t v;
      v.x = 10'(x); v.y = 10'(y); v.on = on;
      v.key = 3'(key); v.oct = oct; v.ev = ev;
      return v;
   endfunction

   // One frame: vsync high for 3 cycles, then falls (cycle T). Samples
   // note_on/key_event at the negedges of T..T+3, returns 2 edges after T+1.
   task automatic do_frame(input int x, input int y);
      bus.center_x = 10'(x);
      bus.center_y = 10'(y);
      bus.vsync    = 1'b1;
      repeat (3) tick();
      bus.vsync = 1'b0;
      ev_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         on_s[i] = bus.note_on;
         ev_s[i] = bus.key_event;
         if (bus.key_event) ev_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   // Called right after the do_frame that started a note: two edges have
   // passed since note_on rose, so counting resumes at 2.
   task automatic wait_rise(input string name, input int exp);
      int n;
      n = 1;
      do begin
         @(negedge clk);
         n++;
      end while (bus.buzzer !== 1'b1 && n < exp + 100);
      check(name, n, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.vsync = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mk(100, 400, 0, 0, 0, 0);
      vecs[1]  = mk(100, 400, 0, 0, 0, 0);
      vecs[2]  = mk(300, 400, 0, 0, 0, 0);
      vecs[3]  = mk(300, 400, 0, 0, 0, 0);
      vecs[4]  = mk(300, 400, 1, 3, 1, 1);
      vecs[5]  = mk(100, 400, 1, 3, 1, 0);
      vecs[6]  = mk(300, 400, 1, 3, 1, 0);
      vecs[7]  = mk(100, 100, 1, 3, 1, 0);
      vecs[8]  = mk(100, 100, 0, 3, 1, 0);
      vecs[9]  = mk(640, 400, 0, 3, 1, 0);
      vecs[10] = mk(640, 400, 0, 3, 1, 0);
      vecs[11] = mk(640, 400, 0, 3, 1, 0);
      vecs[12] = mk(639, 479, 0, 3, 1, 0);
      vecs[13] = mk(639, 479, 0, 3, 1, 0);
      vecs[14] = mk(639, 479, 1, 7, 0, 1);
      vecs[15] = mk(639, 359, 1, 7, 0, 0);
      vecs[16] = mk(639, 480, 0, 7, 0, 0);
      vecs[17] = mk(0,   360, 0, 7, 0, 0);
      vecs[18] = mk(79,  400, 0, 7, 0, 0);
      vecs[19] = mk(0,   418, 1, 0, 1, 1);
      vecs[20] = mk(80,  400, 1, 0, 1, 0);
      vecs[21] = mk(160, 400, 0, 0, 1, 0);
      vecs[22] = mk(160, 400, 0, 0, 1, 0);
      vecs[23] = mk(559, 400, 0, 0, 1, 0);
      vecs[24] = mk(559, 400, 0, 0, 1, 0);
      vecs[25] = mk(559, 400, 1, 6, 1, 1);

      reset = 1'b1;
      bus.vsync = 1'b0;
      bus.center_x = '0;
      bus.center_y = '0;
      repeat (3) tick();
      @(negedge clk);
      check("reset note_on",   int'(bus.note_on),   0);
      check("reset key_idx",   int'(bus.key_idx),   0);
      check("reset key_event", int'(bus.key_event), 0);
      check("reset octave",    int'(bus.octave),    0);
      check("reset buzzer",    int'(bus.buzzer),    0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      // Note start latency, single key_event pulse, first buzzer rise.
      do_frame(100, 400);
      check("start f1 note_on", int'(bus.note_on), 0);
      do_frame(100, 400);
      check("start f2 note_on", int'(bus.note_on), 0);
      do_frame(100, 400);
      check("start note_on T",    int'(on_s[0]), 0);
      check("start note_on T+1",  int'(on_s[1]), 0);
      check("start note_on T+2",  int'(on_s[2]), 1);
      check("start key_event T+2", int'(ev_s[2]), 1);
      check("start key_event T+3", int'(ev_s[3]), 0);
      check("start key_event count", ev_cnt, 1);
      check("start key_idx", int'(bus.key_idx), 1);
      check("start buzzer low", int'(bus.buzzer), 0);
      wait_rise("key1 first buzzer rise", HP_KEY1);

      // Asynchronous reset between clock edges while the buzzer is high.
      #2;
      reset = 1'b1;
      #1;
      check("async reset note_on", int'(bus.note_on), 0);
      check("async reset buzzer",  int'(bus.buzzer),  0);
      check("async reset key_idx", int'(bus.key_idx), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      do_frame(100, 400);
      check("restart f1 note_on", int'(bus.note_on), 0);
      do_frame(100, 400);
      check("restart f2 note_on", int'(bus.note_on), 0);
      do_frame(100, 400);
      check("restart f3 note_on", int'(bus.note_on), 1);
      check("restart key_event count", ev_cnt, 1);
      check("restart key_idx", int'(bus.key_idx), 1);

      do_reset();
      for (int i = 0; i < 26; i++) begin
         do_frame(int'(vecs[i].x), int'(vecs[i].y));
         check($sformatf("vec%0d note_on", i),   int'(bus.note_on), int'(vecs[i].on));
         check($sformatf("vec%0d key_idx", i),   int'(bus.key_idx), int'(vecs[i].key));
         check($sformatf("vec%0d octave", i),    int'(bus.octave),  int'(OCT_EN & vecs[i].oct));
         check($sformatf("vec%0d key_event", i), ev_cnt,            vecs[i].ev);
         if (!vecs[i].on) begin
            check($sformatf("vec%0d buzzer", i), int'(bus.buzzer), 0);
         end
      end

`ifdef FKP_OCTAVE_EN
      do_reset();
      repeat (3) do_frame(560, 370);
      check("oct note_on", int'(bus.note_on), 1);
      check("oct octave",  int'(bus.octave),  1);
      check("oct key_idx", int'(bus.key_idx), 7);
      wait_rise("oct key7 first buzzer rise", 11944);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/finger_key_player.md
# finger_key_player

Frame-rate consumer of the color tracker's `center_x`/`center_y` outputs. Samples the tracked fingertip once per frame and maps it to one of eight on-screen piano keys. Debounces key entry and exit over whole frames, then drives a square-wave tone (C4..C5) on a single-bit buzzer pin. It sits between the tracker and the board's piezo/PWM pin, in the `clk` (25 MHz pixel) domain.

## Interface
- `KEY_Y_MIN`, default 360: top row (inclusive) of the keyboard band.
- `KEY_Y_MAX`, default 479: bottom row (inclusive) of the keyboard band.
- `STABLE_FRAMES`, default 3: consecutive same-key frames needed to start a note; legal range 1..15.
- `RELEASE_FRAMES`, default 2: consecutive off-key frames needed to stop a note; legal range 1..15.
- `clk`  input  1  pixel clock, 25 MHz; the only clock.
- `reset`  input  1  asynchronous, active-high reset.
- `vsync`  input  1  camera vsync, same signal the tracker uses.
- `center_x`  input  10  tracker X centroid.
- `center_y`  input  10  tracker Y centroid.
- `key_idx`  output  3  key currently sounding (0 = C4 … 7 = C5).
- `note_on`  output  1  high while a note sounds.
- `key_event`  output  1  one-cycle pulse when a note starts.
- `octave`  output  1  high when the upper-octave row is active.
- `buzzer`  output  1  square-wave tone output.

## Operation
- Frame tick:
  - `vsync_d` is `vsync` registered; `frame_tick = vsync_d & ~vsync`.
  - `sample_tick` is `frame_tick` registered, so sampling happens one cycle after the tracker updates its centroid.
  - All FSM evaluation happens only on `sample_tick`.
- Zone decode (combinational, on the current center):
  - Valid iff `center_x < 640` and `KEY_Y_MIN <= center_y <= KEY_Y_MAX`.
  - Key = `center_x / 80`, implemented as a compare chain against 80, 160, …, 560; no divider.
- FSM states: IDLE, CAND, PLAY. `cnt` is 4 bits; `cand` is 3 bits.
  - IDLE, valid zone:
    - If `STABLE_FRAMES == 1`, go to PLAY.
    - Otherwise go to CAND with `cand = zone` and `cnt = 1`.
  - CAND, same zone:
    - `cnt + 1 == STABLE_FRAMES`: go to PLAY with `key_idx = cand`.
    - Otherwise increment `cnt`.
  - CAND, different valid zone: `cand = zone`, `cnt = 1`, stay in CAND.
  - CAND, invalid zone: go to IDLE.
  - PLAY, zone equals `key_idx`: clear `cnt`.
  - PLAY, otherwise (different key or invalid):
    - `cnt + 1 == RELEASE_FRAMES`: go to IDLE.
    - Otherwise increment `cnt`.
  - A different key never retriggers directly; it re-enters through IDLE/CAND.
- Tone generator:
  - 16-bit `tcnt`, active only in PLAY.
  - When `tcnt == half_period - 1`: clear `tcnt` and toggle `buzzer`.
  - Outside PLAY, `tcnt = 0` and `buzzer = 0`.
  - On PLAY entry, `tcnt = 0` and `buzzer = 0`.
- `key_idx` holds its last value after release. `note_on` is high iff state is PLAY.

## Timing
- Reset values: state IDLE, `cnt` 0, `cand` 0, `key_idx` 0, `note_on` 0, `key_event` 0, `octave` 0, `buzzer` 0, `tcnt` 0, `vsync_d` 0.
- Cycle numbering: the vsync falling-edge cycle is T.
  - `sample_tick` is high in T+1.
  - State, `note_on`, `key_idx` and `key_event` update at the edge ending T+1.
- Note start: `note_on` rises 2 cycles after the vsync fall of the STABLE_FRAMES-th consistent frame. `key_event` is high for that same single cycle.
- First `buzzer` rise occurs `half_period` cycles after `note_on` rises.
- Leaving PLAY: `buzzer` is forced 0 in the same cycle `note_on` falls.
- Center changes between ticks are ignored.
- Reset mid-note: all outputs return to their reset values immediately (asynchronous).

## Configuration
- `FKP_OCTAVE_EN` defined:
  - The band splits at `mid = (KEY_Y_MIN + KEY_Y_MAX) >> 1`.
  - `center_y < mid` selects the upper octave; `octave` is latched together with `key_idx`.
  - The active half-period is `table >> 1`.
  - A change of octave on the same key counts as a different zone.
- `FKP_OCTAVE_EN` undefined: `octave` is tied 0 and the full table value is used.

## Structure
- Package `fkp_pkg`:
  - State enum `fkp_state_t` (IDLE, CAND, PLAY).
  - `KEY_W = 80`, `FRAME_W = 640`.
  - `HALF_PERIOD[8]` at 25 MHz: 47778, 42566, 37921, 35793, 31888, 28409, 25310, 23889.
- One sub-module, `fkp_tone_gen`:
  - Inputs: `clk`, `reset`, `enable`, 16-bit `half_period`.
  - Output: `buzzer`.
  - Contains the `tcnt` and toggle logic.

## Test plan
- Reset, then center (100, 400) for 3 frames → `note_on` rises after the 3rd vsync fall, `key_idx = 1`, one `key_event` pulse; `buzzer` period is 85132 cycles.
- Center (100, 400) for 2 frames, then (300, 400) → no note; after 3 more frames at (300, 400), `key_idx = 3`.
- While playing key 1, center goes to (100, 100) for 1 frame and then back → note is held. With 2 off frames → `note_on` and `buzzer` go to 0 and `key_idx` stays 1.
- Center (639, 479) vs (640, 400) → key 7 plays; x = 640 never plays.
- With `FKP_OCTAVE_EN` defined, center (560, 370) for 3 frames → `octave = 1`, `key_idx = 7`, `buzzer` half-period 11944 cycles.
- Reset asserted mid-note, between two clock edges → `buzzer` and `note_on` go to 0 asynchronously; after release, 3 frames are needed to restart.
